// File: rtl/ex_operand_stage_pkg.sv
// rtl/ex_operand_stage_pkg.sv - shared ALU codes, forward-select encoding and pipeline entry type
package ex_operand_stage_pkg;

    localparam logic [3:0] ALU_AND         = 4'd0;
    localparam logic [3:0] ALU_OR          = 4'd1;
    localparam logic [3:0] ALU_ADD         = 4'd2;
    localparam logic [3:0] ALU_SUB         = 4'd3;
    localparam logic [3:0] ALU_SLTU        = 4'd4;
    localparam logic [3:0] ALU_SRL         = 4'd5;
    localparam logic [3:0] ALU_SLL         = 4'd6;
    localparam logic [3:0] ALU_SLT         = 4'd7;
    localparam logic [3:0] ALU_MUL         = 4'd8;
    localparam logic [3:0] ALU_LUI         = 4'd14;
    localparam logic [3:0] ALU_CTRL_BUBBLE = 4'hF;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EXM = 2'd1,
        FWD_MWB = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [4:0]  rd_addr;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [15:0] imm;
        logic [4:0]  shamt;
        logic [3:0]  alu_ctrl;
        logic        alusrc;
        logic        shamt_sel;
        logic        zext;
    } ex_entry_t;

    function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic zext);
        return zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// rtl/ex_operand_stage_fwd_mux.sv - one source operand's EX/MEM and MEM/WB bypass selection
module fwd_mux
    import ex_operand_stage_pkg::*;
#(
    parameter int FWD_EN = 1
) (
    input  logic [4:0]  addr_i,
    input  logic [31:0] rf_data_i,
    input  logic        exm_regwrite_i,
    input  logic [4:0]  exm_rd_i,
    input  logic [31:0] exm_result_i,
    input  logic        mwb_regwrite_i,
    input  logic [4:0]  mwb_rd_i,
    input  logic [31:0] mwb_data_i,
    output logic [31:0] data_o
);

    fwd_sel_e sel;

    // The younger EX/MEM result wins over MEM/WB; r0 is hard-wired and never bypassed.
    always_comb begin
        sel = FWD_RF;
        if (FWD_EN != 0) begin
            if (exm_regwrite_i && (exm_rd_i != 5'd0) && (exm_rd_i == addr_i)) begin
                sel = FWD_EXM;
            end else if (mwb_regwrite_i && (mwb_rd_i != 5'd0) && (mwb_rd_i == addr_i)) begin
                sel = FWD_MWB;
            end
        end
    end

    always_comb begin
        case (sel)
            FWD_EXM: data_o = exm_result_i;
            FWD_MWB: data_o = mwb_data_i;
            default: data_o = rf_data_i;
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX pipeline register with operand forwarding and selection
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int FWD_EN = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        id_valid_i,
    input  logic [31:0] id_rs_data_i,
    input  logic [31:0] id_rt_data_i,
    input  logic [4:0]  id_rs_addr_i,
    input  logic [4:0]  id_rt_addr_i,
    input  logic [4:0]  id_rd_addr_i,
    input  logic [15:0] id_imm_i,
    input  logic [4:0]  id_shamt_i,
    input  logic [3:0]  id_alu_ctrl_i,
    input  logic        id_alusrc_i,
    input  logic        id_shamt_sel_i,
    input  logic        id_zext_i,
    input  logic        id_regwrite_i,
    input  logic        exm_regwrite_i,
    input  logic [4:0]  exm_rd_i,
    input  logic [31:0] exm_result_i,
    input  logic        mwb_regwrite_i,
    input  logic [4:0]  mwb_rd_i,
    input  logic [31:0] mwb_data_i,
    output logic [31:0] src1_o,
    output logic [31:0] src2_o,
    output logic [3:0]  ctrl_o,
    output logic        valid_o,
    output logic        regwrite_o,
    output logic [4:0]  wr_addr_o,
    output logic [31:0] rt_fwd_o
);

    ex_entry_t entry_q, entry_d, id_entry;
    logic [31:0] rs_fwd, rt_fwd;

    always_comb begin
        id_entry.valid     = id_valid_i;
        id_entry.regwrite  = id_regwrite_i;
        id_entry.rs_addr   = id_rs_addr_i;
        id_entry.rt_addr   = id_rt_addr_i;
        id_entry.rd_addr   = id_rd_addr_i;
        id_entry.rs_data   = id_rs_data_i;
        id_entry.rt_data   = id_rt_data_i;
        id_entry.imm       = id_imm_i;
        id_entry.shamt     = id_shamt_i;
        id_entry.alu_ctrl  = id_alu_ctrl_i;
        id_entry.alusrc    = id_alusrc_i;
        id_entry.shamt_sel = id_shamt_sel_i;
        id_entry.zext      = id_zext_i;
    end

    // Flush beats stall so a redirect can never leave a stale instruction held.
    always_comb begin
        entry_d = id_entry;
        if (flush_i) begin
            entry_d.valid    = 1'b0;
            entry_d.regwrite = 1'b0;
        end else if (stall_i) begin
            entry_d = entry_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entry_q          <= '0;
            entry_q.alu_ctrl <= ALU_CTRL_BUBBLE;
        end else begin
            entry_q <= entry_d;
        end
    end

    fwd_mux #(.FWD_EN(FWD_EN)) u_fwd_rs (
        .addr_i        (entry_q.rs_addr),
        .rf_data_i     (entry_q.rs_data),
        .exm_regwrite_i(exm_regwrite_i),
        .exm_rd_i      (exm_rd_i),
        .exm_result_i  (exm_result_i),
        .mwb_regwrite_i(mwb_regwrite_i),
        .mwb_rd_i      (mwb_rd_i),
        .mwb_data_i    (mwb_data_i),
        .data_o        (rs_fwd)
    );

    fwd_mux #(.FWD_EN(FWD_EN)) u_fwd_rt (
        .addr_i        (entry_q.rt_addr),
        .rf_data_i     (entry_q.rt_data),
        .exm_regwrite_i(exm_regwrite_i),
        .exm_rd_i      (exm_rd_i),
        .exm_result_i  (exm_result_i),
        .mwb_regwrite_i(mwb_regwrite_i),
        .mwb_rd_i      (mwb_rd_i),
        .mwb_data_i    (mwb_data_i),
        .data_o        (rt_fwd)
    );

    // An invalid entry presents all-zero operands and the bubble code so the ALU yields 0.
    always_comb begin
        src1_o     = 32'd0;
        src2_o     = 32'd0;
        ctrl_o     = ALU_CTRL_BUBBLE;
        rt_fwd_o   = 32'd0;
        valid_o    = entry_q.valid;
        regwrite_o = entry_q.valid & entry_q.regwrite;
        wr_addr_o  = entry_q.rd_addr;
        if (entry_q.valid) begin
            src1_o   = entry_q.shamt_sel ? {27'd0, entry_q.shamt} : rs_fwd;
            src2_o   = entry_q.alusrc ? ext_imm(entry_q.imm, entry_q.zext) : rt_fwd;
            ctrl_o   = entry_q.alu_ctrl;
            rt_fwd_o = rt_fwd;
        end
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - randomized self-checking bench for ex_operand_stage
module tb_ex_operand_stage;

    logic        clk_i = 1'b0;
    logic        rst_i, stall_i, flush_i, id_valid_i;
    logic [31:0] id_rs_data_i, id_rt_data_i;
    logic [4:0]  id_rs_addr_i, id_rt_addr_i, id_rd_addr_i;
    logic [15:0] id_imm_i;
    logic [4:0]  id_shamt_i;
    logic [3:0]  id_alu_ctrl_i;
    logic        id_alusrc_i, id_shamt_sel_i, id_zext_i, id_regwrite_i;
    logic        exm_regwrite_i, mwb_regwrite_i;
    logic [4:0]  exm_rd_i, mwb_rd_i;
    logic [31:0] exm_result_i, mwb_data_i;
    logic [31:0] src1_o, src2_o, rt_fwd_o;
    logic [3:0]  ctrl_o;
    logic        valid_o, regwrite_o;
    logic [4:0]  wr_addr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ex_operand_stage #(.FWD_EN(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i),
        .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i), .id_rd_addr_i(id_rd_addr_i),
        .id_imm_i(id_imm_i), .id_shamt_i(id_shamt_i), .id_alu_ctrl_i(id_alu_ctrl_i),
        .id_alusrc_i(id_alusrc_i), .id_shamt_sel_i(id_shamt_sel_i), .id_zext_i(id_zext_i),
        .id_regwrite_i(id_regwrite_i),
        .exm_regwrite_i(exm_regwrite_i), .exm_rd_i(exm_rd_i), .exm_result_i(exm_result_i),
        .mwb_regwrite_i(mwb_regwrite_i), .mwb_rd_i(mwb_rd_i), .mwb_data_i(mwb_data_i),
        .src1_o(src1_o), .src2_o(src2_o), .ctrl_o(ctrl_o), .valid_o(valid_o),
        .regwrite_o(regwrite_o), .wr_addr_o(wr_addr_o), .rt_fwd_o(rt_fwd_o)
    );

    // Reference model: the instruction currently sitting in EX, as plain fields.
    typedef struct {
        bit        v, rw, alusrc, shsel, zext;
        bit [4:0]  rs, rt, rd, sh;
        bit [31:0] rsd, rtd;
        bit [15:0] imm;
        bit [3:0]  ctrl;
    } instr_t;

    instr_t m;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit [31:0] model_fwd(input bit [4:0] a, input bit [31:0] rf);
        if (exm_regwrite_i && exm_rd_i != 0 && exm_rd_i == a) return exm_result_i;
        if (mwb_regwrite_i && mwb_rd_i != 0 && mwb_rd_i == a) return mwb_data_i;
        return rf;
    endfunction

    function automatic instr_t from_id();
        instr_t t;
        t.v = id_valid_i; t.rw = id_regwrite_i; t.alusrc = id_alusrc_i;
        t.shsel = id_shamt_sel_i; t.zext = id_zext_i;
        t.rs = id_rs_addr_i; t.rt = id_rt_addr_i; t.rd = id_rd_addr_i; t.sh = id_shamt_i;
        t.rsd = id_rs_data_i; t.rtd = id_rt_data_i; t.imm = id_imm_i; t.ctrl = id_alu_ctrl_i;
        return t;
    endfunction

    task automatic check_outputs(input string tag);
        bit [31:0] rsf, rtf, immx, e1, e2, ert;
        bit [3:0]  ec;
        rsf  = model_fwd(m.rs, m.rsd);
        rtf  = model_fwd(m.rt, m.rtd);
        immx = m.zext ? {16'h0, m.imm} : {{16{m.imm[15]}}, m.imm};
        e1 = 0; e2 = 0; ert = 0; ec = 4'hF;
        if (m.v) begin
            e1  = m.shsel ? {27'd0, m.sh} : rsf;
            e2  = m.alusrc ? immx : rtf;
            ert = rtf;
            ec  = m.ctrl;
        end
        check_eq({tag, ".src1"}, src1_o, e1);
        check_eq({tag, ".src2"}, src2_o, e2);
        check_eq({tag, ".ctrl"}, {28'd0, ctrl_o}, {28'd0, ec});
        check_eq({tag, ".valid"}, {31'd0, valid_o}, {31'd0, m.v});
        check_eq({tag, ".regwrite"}, {31'd0, regwrite_o}, {31'd0, m.v & m.rw});
        check_eq({tag, ".wr_addr"}, {27'd0, wr_addr_o}, {27'd0, m.rd});
        check_eq({tag, ".rt_fwd"}, rt_fwd_o, ert);
    endtask

    // Drive control inputs, advance one edge, and advance the model the same way.
    task automatic clock(input bit rst, input bit stall, input bit flush);
        instr_t nxt;
        rst_i = rst; stall_i = stall; flush_i = flush;
        if (rst) begin
            nxt = '{default: 0};
            nxt.ctrl = 4'hF;
        end else if (flush) begin
            nxt = from_id();
            nxt.v = 0; nxt.rw = 0;
        end else if (stall) begin
            nxt = m;
        end else begin
            nxt = from_id();
        end
        @(posedge clk_i);
        m = nxt;
        #1;
        rst_i = 0; stall_i = 0; flush_i = 0;
    endtask

    task automatic rand_id();
        id_valid_i     = ($urandom_range(0, 7) != 0);
        id_rs_data_i   = $urandom;
        id_rt_data_i   = $urandom;
        id_rs_addr_i   = 5'($urandom_range(0, 3));
        id_rt_addr_i   = 5'($urandom_range(0, 3));
        id_rd_addr_i   = 5'($urandom);
        id_imm_i       = 16'($urandom);
        id_shamt_i     = 5'($urandom);
        id_alu_ctrl_i  = 4'($urandom);
        id_alusrc_i    = 1'($urandom);
        id_shamt_sel_i = 1'($urandom);
        id_zext_i      = 1'($urandom);
        id_regwrite_i  = 1'($urandom);
    endtask

    task automatic rand_fwd();
        exm_regwrite_i = 1'($urandom);
        exm_rd_i       = 5'($urandom_range(0, 3));
        exm_result_i   = $urandom;
        mwb_regwrite_i = 1'($urandom);
        mwb_rd_i       = 5'($urandom_range(0, 3));
        mwb_data_i     = $urandom;
    endtask

    task automatic set_plain_id();
        id_valid_i = 1; id_regwrite_i = 1; id_alusrc_i = 0; id_shamt_sel_i = 0; id_zext_i = 0;
        id_rs_addr_i = 5'd1; id_rt_addr_i = 5'd2; id_rd_addr_i = 5'd9;
        id_rs_data_i = 32'h99; id_rt_data_i = 32'h77; id_imm_i = 16'h0; id_shamt_i = 0;
        id_alu_ctrl_i = 4'd2;
        exm_regwrite_i = 0; exm_rd_i = 0; exm_result_i = 0;
        mwb_regwrite_i = 0; mwb_rd_i = 0; mwb_data_i = 0;
    endtask

    logic [31:0] held_src1, held_src2, held_rt;
    logic [4:0]  held_wa;

    initial begin
        rst_i = 1; stall_i = 0; flush_i = 0;
        set_plain_id();

        clock(1, 1, 1);
        check_eq("reset.valid", {31'd0, valid_o}, 32'd0);
        check_eq("reset.ctrl", {28'd0, ctrl_o}, 32'hF);
        check_eq("reset.wr_addr", {27'd0, wr_addr_o}, 32'd0);
        check_outputs("reset");

        // Forwarding priority on rs
        set_plain_id();
        id_rs_addr_i = 5'd5;
        clock(0, 0, 0);
        exm_regwrite_i = 1; exm_rd_i = 5'd5; exm_result_i = 32'h11;
        mwb_regwrite_i = 1; mwb_rd_i = 5'd5; mwb_data_i = 32'h22;
        #1;
        check_eq("fwd_exm_first", src1_o, 32'h11);
        exm_regwrite_i = 0;
        #1;
        check_eq("fwd_mwb_second", src1_o, 32'h22);
        check_outputs("fwd_prio");

        // Register 0 is never forwarded
        set_plain_id();
        id_rt_addr_i = 5'd0; id_rt_data_i = 32'd0;
        exm_regwrite_i = 1; exm_rd_i = 5'd0; exm_result_i = 32'hDEAD;
        clock(0, 0, 0);
        check_eq("r0_no_fwd", src2_o, 32'd0);
        check_outputs("r0");

        // Immediate extension and shift-amount source
        set_plain_id();
        id_alusrc_i = 1; id_imm_i = 16'h8000; id_zext_i = 0;
        clock(0, 0, 0);
        check_eq("imm_sext", src2_o, 32'hFFFF8000);
        id_zext_i = 1;
        clock(0, 0, 0);
        check_eq("imm_zext", src2_o, 32'h00008000);
        id_shamt_sel_i = 1; id_shamt_i = 5'd3; id_alu_ctrl_i = 4'd6;
        clock(0, 0, 0);
        check_eq("shamt_src1", src1_o, 32'd3);
        check_outputs("opsel");

        // Stall holds, then simultaneous stall+flush yields a bubble
        set_plain_id();
        id_rd_addr_i = 5'd17; id_rs_data_i = 32'hA5A5_0001; id_rt_data_i = 32'h5A5A_0002;
        clock(0, 0, 0);
        held_src1 = src1_o; held_src2 = src2_o; held_rt = rt_fwd_o; held_wa = wr_addr_o;
        for (int i = 0; i < 2; i++) begin
            rand_id();
            clock(0, 1, 0);
            check_eq("stall_src1", src1_o, held_src1);
            check_eq("stall_src2", src2_o, held_src2);
            check_eq("stall_rt", rt_fwd_o, held_rt);
            check_eq("stall_wa", {27'd0, wr_addr_o}, {27'd0, held_wa});
        end
        clock(0, 1, 1);
        check_eq("flush_wins.valid", {31'd0, valid_o}, 32'd0);
        check_eq("flush_wins.ctrl", {28'd0, ctrl_o}, 32'hF);
        check_outputs("flush_wins");

        // Reset mid-stall discards a valid writing entry
        set_plain_id();
        clock(0, 0, 0);
        check_eq("pre_rst.regwrite", {31'd0, regwrite_o}, 32'd1);
        clock(1, 1, 0);
        check_eq("rst_mid.valid", {31'd0, valid_o}, 32'd0);
        check_eq("rst_mid.regwrite", {31'd0, regwrite_o}, 32'd0);
        check_eq("rst_mid.wr_addr", {27'd0, wr_addr_o}, 32'd0);
        check_eq("rst_mid.src1", src1_o, 32'd0);
        check_eq("rst_mid.ctrl", {28'd0, ctrl_o}, 32'hF);
        check_outputs("rst_mid");

        // Random traffic; forwarding inputs also change between edges
        for (int i = 0; i < 400; i++) begin
            rand_id();
            rand_fwd();
            clock($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0);
            check_outputs("rand_edge");
            rand_fwd();
            #1;
            check_outputs("rand_fwd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
